// File: rtl/response_checker.sv
// Sequences a 4-input unit under test through its 16 vectors and scores each response.
// Optional feature: define CHK_COMPLEMENT_EN to also flag fb != ~f.
module response_checker #(
  parameter logic [15:0] EXP_F  = 16'h0000,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [3:0]       vec,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic             f,
  input  logic             fb,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       first_fail_vec,
  output logic             fail_seen,
  output logic             done,
  output logic             pass
);

  localparam logic [3:0]       WAIT_INIT = 4'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [3:0]       vec_q, vec_d;
  logic [15:0]      cov_q, cov_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       ffv_q, ffv_d;
  logic             fail_q, fail_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             err_s;

`ifndef CHK_COMPLEMENT_EN
  logic unused_fb_s;
  assign unused_fb_s = fb;
`endif

  // Response mismatch for the latched vector; both faults together still count once.
  always_comb begin
    err_s = 1'b0;
`ifdef CHK_COMPLEMENT_EN
    err_s = (f != EXP_F[vec_q]) || (fb != ~f);
`else
    err_s = (f != EXP_F[vec_q]);
`endif
  end

  // Next-state and statistics update; clr overrides any handshake or check in progress.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    vec_d   = vec_q;
    cov_d   = cov_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    fail_d  = fail_q;
    if (clr) begin
      state_d = ST_IDLE;
      wait_d  = 4'h0;
      vec_d   = 4'h0;
      cov_d   = 16'h0000;
      err_d   = '0;
      ffv_d   = 4'h0;
      fail_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (vec_valid) begin
            vec_d   = vec;
            wait_d  = WAIT_INIT;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (wait_q == 4'h0) begin
            state_d = ST_CHECK;
          end else begin
            wait_d = wait_q - 4'h1;
          end
        end
        ST_CHECK: begin
          cov_d = cov_q | (16'h0001 << vec_q);
          if (err_s) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_ONE;
            end else begin
              err_d = err_q;
            end
            if (!fail_q) begin
              fail_d = 1'b1;
              ffv_d  = vec_q;
            end else begin
              fail_d = fail_q;
            end
          end else begin
            err_d = err_q;
          end
          if (cov_d == 16'hFFFF) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Verdict flags track the upcoming state so they appear with the final check result.
  always_comb begin
    done_d = (state_d == ST_DONE);
    pass_d = done_d && !fail_d;
  end

  // State and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= 4'h0;
      vec_q   <= 4'h0;
      cov_q   <= 16'h0000;
      err_q   <= '0;
      ffv_q   <= 4'h0;
      fail_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      vec_q   <= vec_d;
      cov_q   <= cov_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      fail_q  <= fail_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign vec_ready      = (state_q == ST_IDLE);
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;
  assign fail_seen      = fail_q;
  assign done           = done_q;
  assign pass           = pass_q;

endmodule

// File: tb/tb_response_checker.sv
// Directed and randomized scoring bench for response_checker; a 5-bit and a 2-bit
// error-counter instance share one stimulus stream.
module tb_response_checker;
  localparam logic [15:0] EXP = 16'h1E6A;
  localparam int          ST  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       vec_valid = 1'b0;
  logic       f = 1'b0;
  logic       fb = 1'b1;
  logic [3:0] vec = 4'h0;

  logic       rdy_a, fs_a, done_a, pass_a;
  logic [4:0] err_a;
  logic [3:0] ffv_a;
  logic       rdy_b, fs_b, done_b, pass_b;
  logic [1:0] err_b;
  logic [3:0] ffv_b;

  response_checker #(.EXP_F(EXP), .SETTLE(ST), .ERR_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .vec(vec), .vec_valid(vec_valid),
    .vec_ready(rdy_a), .f(f), .fb(fb), .err_count(err_a),
    .first_fail_vec(ffv_a), .fail_seen(fs_a), .done(done_a), .pass(pass_a));

  response_checker #(.EXP_F(EXP), .SETTLE(ST), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .vec(vec), .vec_valid(vec_valid),
    .vec_ready(rdy_b), .f(f), .fb(fb), .err_count(err_b),
    .first_fail_vec(ffv_b), .fail_seen(fs_b), .done(done_b), .pass(pass_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: what has been seen, not how the checker sequences it.
  logic [15:0] exp_tab = EXP;
  int          m_err;
  logic [3:0]  m_ffv;
  bit          m_fail;
  bit          m_cov [16];
  int          m_ncov;

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  task automatic model_clear();
    m_err = 0; m_ffv = 4'h0; m_fail = 1'b0; m_ncov = 0;
    for (int i = 0; i < 16; i++) m_cov[i] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    bit exp_done;
    exp_done = (m_ncov == 16);
    chk({tag, "/err"},   32'(err_a), 32'(sat(m_err, 31)));
    chk({tag, "/err2"},  32'(err_b), 32'(sat(m_err, 3)));
    chk({tag, "/ffv"},   32'(ffv_a), 32'(m_ffv));
    chk({tag, "/fail"},  32'(fs_a),  32'(m_fail));
    chk({tag, "/done"},  32'(done_a), 32'(exp_done));
    chk({tag, "/pass"},  32'(pass_a), 32'(exp_done && !m_fail));
    chk({tag, "/ready"}, 32'(rdy_a), 32'(!exp_done));
    chk({tag, "/done2"}, 32'(done_b), 32'(exp_done));
  endtask

  task automatic do_clr(input string tag);
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    model_clear();
    check_outputs(tag);
  endtask

  // One vector: handshake, scramble vec while busy, then score the response.
  task automatic send(input logic [3:0] v, input bit wf, input bit wfb, output int hs);
    bit e;
    @(negedge clk);
    chk("pre_ready", 32'(rdy_a), 32'd1);
    vec = v; vec_valid = 1'b1;
    f = exp_tab[v] ^ wf;
    fb = wfb ? f : ~f;
    @(posedge clk); #1;
    hs = cyc;
    vec = 4'($urandom);
    repeat (ST) @(posedge clk);
    #1;
    chk("busy_ready", 32'(rdy_a), 32'd0);
    chk("busy_err", 32'(err_a), 32'(sat(m_err, 31)));
    @(posedge clk); #1;
    e = wf;
`ifdef CHK_COMPLEMENT_EN
    e = e | wfb;
`endif
    if (e) begin
      m_err++;
      if (!m_fail) begin m_fail = 1'b1; m_ffv = v; end
    end
    if (!m_cov[v]) begin m_cov[v] = 1'b1; m_ncov++; end
    vec_valid = 1'b0;
    check_outputs($sformatf("vec%0d", v));
  endtask

  initial begin
    int hs, hs_prev, k;
    bit wf;
    logic [3:0] v;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(rdy_a), 32'd1);

    // All-correct sweep with back-to-back handshakes.
    hs_prev = 0;
    for (int i = 0; i < 16; i++) begin
      send(4'(i), 1'b0, 1'b0, hs);
      if (i > 0) chk("spacing", 32'(hs - hs_prev), 32'(ST + 2));
      hs_prev = hs;
    end
    repeat (3) @(posedge clk);
    #1;
    check_outputs("done_hold");

    // Faulty responses on vectors 5 and 9.
    do_clr("clr1");
    for (int i = 0; i < 16; i++) send(4'(i), (i == 5) || (i == 9), 1'b0, hs);

    // Repeated faulty vector 3 followed by a clean sweep.
    do_clr("clr2");
    for (int i = 0; i < 3; i++) send(4'd3, 1'b1, 1'b0, hs);
    for (int i = 0; i < 16; i++) send(4'(i), 1'b0, 1'b0, hs);

    // Random vectors and faults; the first six are faults to drive saturation.
    do_clr("clr3");
    k = 0;
    while (m_ncov < 16 && k < 300) begin
      v = 4'($urandom_range(15));
      wf = (k < 6) ? 1'b1 : ($urandom_range(3) == 0);
      send(v, wf, 1'b0, hs);
      k++;
    end
    chk("rand_covered", 32'(m_ncov), 32'd16);

    // Reset in the middle of settling vector 7.
    do_clr("clr4");
    for (int i = 0; i < 7; i++) send(4'(i), 1'b1, 1'b0, hs);
    @(negedge clk); vec = 4'd7; vec_valid = 1'b1; f = exp_tab[7]; fb = ~f;
    @(posedge clk); #1; vec_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    model_clear();
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_err2", 32'(err_b), 32'd0);
    chk("rst_ffv", 32'(ffv_a), 32'd0);
    chk("rst_fail", 32'(fs_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(rdy_a), 32'd1);
    for (int i = 0; i < 16; i++) if (i != 7) send(4'(i), 1'b0, 1'b0, hs);
    send(4'd7, 1'b0, 1'b0, hs);

    // Complement output wrong while f is right.
    do_clr("clr5");
    send(4'd2, 1'b0, 1'b1, hs);
    send(4'd3, 1'b1, 1'b1, hs);

    // clr together with a handshake discards the vector.
    do_clr("clr6");
    @(negedge clk); clr = 1'b1; vec = 4'd4; vec_valid = 1'b1; f = ~exp_tab[4]; fb = ~f;
    @(posedge clk); #1; clr = 1'b0; vec_valid = 1'b0;
    chk("clr_hs_ready", 32'(rdy_a), 32'd1);
    repeat (ST + 3) @(posedge clk);
    #1;
    check_outputs("clr_hs");

    // clr on the checking edge discards the faulty result.
    @(negedge clk); vec = 4'd4; vec_valid = 1'b1; f = ~exp_tab[4]; fb = ~f;
    @(posedge clk); #1; vec_valid = 1'b0;
    repeat (ST + 1) @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("clr_check");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
